// File: rtl/seq_addsub_unit_pkg.sv
// Shared definitions for the sliced add/subtract unit: FSM encoding, slice
// geometry helpers, parameter legality check and the one-bit full-adder cell.
package seq_addsub_unit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } flags_t;

    function automatic bit cfg_legal(input int width, input int chunk);
        return (chunk >= 32'sd1) && (width >= 32'sd1) && ((width % chunk) == 32'sd0);
    endfunction

    function automatic int calc_nchunk(input int width, input int chunk);
        return (chunk >= 32'sd1) ? (width / chunk) : 32'sd1;
    endfunction

    // At least one index bit so the single-slice configuration stays legal.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 32'sd1) ? $clog2(nchunk) : 32'sd1;
    endfunction

    // One-bit full adder cell, returns {cout, sum}.
    function automatic logic [1:0] full_add_bit(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/seq_addsub_unit_if.sv
// Operand-in / result-out handshake bundle of the sliced add/subtract unit.
interface seq_addsub_unit_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero
    );

endinterface

// File: rtl/seq_addsub_unit_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; the top
// level time-multiplexes a single instance across all slices.
module seq_addsub_unit_chunk_adder
    import seq_addsub_unit_pkg::*;
#(
    parameter int CHUNK = 8
) (
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin
);

    logic       carry_s;
    logic [1:0] fa_s;

    // Ripple the carry through the cells LSB to MSB.
    always_comb begin
        sum     = {CHUNK{1'b0}};
        carry_s = cin;
        fa_s    = 2'b00;
        for (int i = 0; i < CHUNK; i++) begin
            fa_s    = full_add_bit(a[i], b[i], carry_s);
            sum[i]  = fa_s[0];
            carry_s = fa_s[1];
        end
        cout = carry_s;
    end

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LSB slice first,
// with the inter-slice carry held in a register.
module seq_addsub_unit
    import seq_addsub_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_addsub_unit_if.slave bus
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam int MSB    = WIDTH - 32'sd1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 32'sd1);

    if (!cfg_legal(WIDTH, CHUNK)) begin : g_cfg_check
        $error("seq_addsub_unit: CHUNK must be >= 1 and divide WIDTH exactly");
    end

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;
    flags_t           flags_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [CHUNK-1:0] a_slice_s;
    logic [CHUNK-1:0] b_slice_s;
    logic [CHUNK-1:0] slice_sum_s;
    logic             slice_cout_s;
    logic [WIDTH-1:0] sum_next_s;
    flags_t           flags_next_s;

    // Select the operand slices addressed by the chunk index.
    always_comb begin
        a_slice_s = {CHUNK{1'b0}};
        b_slice_s = {CHUNK{1'b0}};
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_r == IDX_W'(i)) begin
                a_slice_s = a_r[i*CHUNK +: CHUNK];
                b_slice_s = b_r[i*CHUNK +: CHUNK];
            end else begin
                a_slice_s = a_slice_s;
                b_slice_s = b_slice_s;
            end
        end
    end

    seq_addsub_unit_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .sum  (slice_sum_s),
        .cout (slice_cout_s),
        .a    (a_slice_s),
        .b    (b_slice_s),
        .cin  (carry_r)
    );

    // Merge the fresh slice into the running sum.
    always_comb begin
        sum_next_s = sum_r;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_r == IDX_W'(i)) begin
                sum_next_s[i*CHUNK +: CHUNK] = slice_sum_s;
            end else begin
                sum_next_s[i*CHUNK +: CHUNK] = sum_r[i*CHUNK +: CHUNK];
            end
        end
    end

    // Flags are only meaningful on the last slice, where sum_next_s is complete.
    always_comb begin
        flags_next_s.carry    = slice_cout_s;
        flags_next_s.overflow = (a_r[MSB] == b_r[MSB]) && (sum_next_s[MSB] != a_r[MSB]);
        flags_next_s.zero     = (sum_next_s == {WIDTH{1'b0}});
    end

    // FSM, operand capture, slice sequencing and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            flags_r     <= '{carry: 1'b0, overflow: 1'b0, zero: 1'b0};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.op_a;
                        b_r        <= bus.op_b ^ {WIDTH{bus.sub}};
                        carry_r    <= bus.sub;
                        idx_r      <= {IDX_W{1'b0}};
                        sum_r      <= {WIDTH{1'b0}};
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sum_r   <= sum_next_s;
                    carry_r <= slice_cout_s;
                    if (idx_r == LAST_IDX) begin
                        flags_r     <= flags_next_s;
                        idx_r       <= {IDX_W{1'b0}};
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.carry_out = flags_r.carry;
    assign bus.overflow  = flags_r.overflow;
    assign bus.zero      = flags_r.zero;

endmodule

// File: doc/seq_addsub_unit.md
# seq_addsub_unit

Parametrised multi-cycle add/subtract unit for the MIPS datapath, successor to the fixed 32-bit ripple-carry adder chain. It accepts two WIDTH-bit operands over a valid/ready handshake and computes A+B or A−B one CHUNK-bit slice per clock, least-significant slice first, carrying between slices in a register. It returns the sum with carry, signed-overflow and zero flags over a second valid/ready handshake. Intended for the ALU/branch-target path, where area matters more than single-cycle latency.

## Interface
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits processed per cycle. Must be ≥1 and divide WIDTH exactly; otherwise elaboration error. NCHUNK = WIDTH/CHUNK.
- clk  in  1  rising-edge clock; sole clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands and mode present.
- in_ready  out  1  unit can accept; equals (state==IDLE).
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result present; equals (state==DONE).
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result.
- carry_out  out  1  carry out of MSB. For subtract, 1 means no borrow.
- overflow  out  1  two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: on in_valid && in_ready, latch op_a and op_b ^ {WIDTH{sub}} into operand registers, and set the carry register to sub. Clear the chunk index, clear sum, go to RUN.
- RUN: each cycle, add slice[idx] of A, slice[idx] of B', and the carry register. Write the CHUNK-bit result to sum[idx*CHUNK +: CHUNK] and the slice carry back into the carry register, then increment idx. When idx == NCHUNK−1, update the flags and go to DONE.
- Flags, registered on the last RUN cycle:
  - carry_out = final slice carry.
  - overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
  - zero = full sum == 0.
- DONE: sum and flags are held stable while out_valid=1. On out_ready, go to IDLE. out_valid never drops without a handshake.
- in_valid is ignored outside IDLE. op_a, op_b and sub may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH. There is no sign extension and no saturation.

## Timing
- Acceptance edge E0. The slice edges are E1..E_NCHUNK. out_valid is high in the cycle after E_NCHUNK, so latency from acceptance to out_valid is NCHUNK cycles.
- If out_ready is already high in DONE, the result transfers at the next edge and in_ready rises in the following cycle. Minimum issue interval is NCHUNK+2 cycles. The unit is non-pipelined, with one operation in flight.
- CHUNK == WIDTH gives a single RUN cycle (latency 1).
- Reset (rst_n=0 sampled at an edge), in any state including mid-RUN or DONE:
  - state→IDLE, sum→0, carry_out/overflow/zero→0, idx→0, carry register→0.
  - out_valid=0 and in_ready=1 from the following cycle.
  - Handshakes are ignored while rst_n=0. The in-flight operation is discarded with no partial result.
- Outputs after reset: in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, zero=0. zero reads 0, not 1, until the first result.

## Structure
- Shared package/header (adder_defs): FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the NCHUNK/index-width derivation, and the parameter legality check.
- Sub-module chunk_adder: a combinational CHUNK-bit adder with ports sum, cout, a, b, cin, built from the existing oneBitFullAdder cells. It is instantiated once and time-multiplexed across slices.
- Top level contains only the FSM, operand/sum/carry/index registers, slice muxing and flag logic.

## Test plan
All scenarios use WIDTH=32, CHUNK=8 unless stated.
- Add 0x000000FF + 0x00000001 → sum 0x00000100, carry 0, ovf 0, zero 0; out_valid exactly 4 cycles after acceptance.
- Add 0xFFFFFFFF + 0x00000001 → sum 0, carry 1, zero 1, ovf 0. Add 0x7FFFFFFF + 1 → 0x80000000, ovf 1, carry 0.
- Sub 5 − 5 → 0, carry 1, zero 1. Sub 0 − 1 → 0xFFFFFFFF, carry 0. Sub 0x80000000 − 1 → 0x7FFFFFFF, ovf 1, carry 1.
- Backpressure: out_ready low for 10 cycles in DONE → sum and flags stable, out_valid held, in_ready 0. A new in_valid with different operands is ignored. Release → one transfer, then IDLE.
- Reset asserted for 1 cycle after 2 slice edges → next cycle out_valid 0, in_ready 1, sum 0. A fresh add of 3 + 4 then returns 7 with no residue from the aborted operation.
- Parameter sweep: CHUNK ∈ {1, 4, 32} and WIDTH=16/CHUNK=4 against a random reference model (1000 ops each, random sub and random out_ready) → all results match. Latency = NCHUNK.
